// File: rtl/sad_best_match.sv
// ============================================================================
// sad_best_match : sequences NUM_CAND SAD engine runs and keeps the minimum
// Rev 1.0
// ============================================================================
`default_nettype none

module sad_best_match #(
  parameter int NUM_CAND = 16,
  parameter int IDX_W    = 4,
  parameter int SAD_W    = 32,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             Mrst,
  input  logic             start,
  output logic             sad_go,
  output logic [IDX_W-1:0] cand_idx,
  input  logic             sad_valid,
  input  logic [SAD_W-1:0] sad,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             err
);

  localparam int WD_W = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CMP    = 3'd3;
  localparam logic [2:0] S_FIN    = 3'd4;

  localparam logic [WD_W-1:0]  c_WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] c_CAND_LAST = IDX_W'(NUM_CAND - 1);

  logic [2:0]       state_q,    state_d;
  logic [IDX_W-1:0] cand_q,     cand_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [SAD_W-1:0] sad_q,      sad_d;
  logic [WD_W-1:0]  wdog_q,     wdog_d;
  logic             err_q,      err_d;
  logic             go_q,       go_d;
  logic             done_q,     done_d;

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    sad_d      = sad_q;
    wdog_d     = wdog_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LAUNCH;
          cand_d     = '0;
          best_sad_d = '1;
          best_idx_d = '0;
          err_d      = 1'b0;
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + WD_W'(1);
        // A result arriving on the final watchdog cycle is still accepted.
        if (sad_valid) begin
          sad_d   = sad;
          state_d = S_CMP;
        end else if (wdog_q == c_WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_CMP: begin
        if (sad_q < best_sad_q) begin
          best_sad_d = sad_q;
          best_idx_d = cand_q;
        end
        if (cand_q == c_CAND_LAST) begin
          state_d = S_FIN;
        end else begin
          cand_d  = cand_q + IDX_W'(1);
          state_d = S_LAUNCH;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pulses are registered from the next state so they align with it.
    go_d   = (state_d == S_LAUNCH);
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clk or negedge Mrst) begin
    if (!Mrst) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      best_sad_q <= '1;
      best_idx_q <= '0;
      sad_q      <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      go_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      sad_q      <= sad_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      go_q       <= go_d;
      done_q     <= done_d;
    end
  end

  assign sad_go   = go_q;
  assign done     = done_q;
  assign cand_idx = cand_q;
  assign busy     = (state_q != S_IDLE);
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_sad_best_match.sv
// ============================================================================
// tb_sad_best_match : directed bench with a fixed-latency SAD engine model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sad_best_match;

  logic        clk;
  logic        Mrst;
  logic        start;
  logic        sad_go;
  logic [3:0]  cand_idx;
  logic        sad_valid;
  logic [31:0] sad;
  logic        busy;
  logic        done;
  logic [31:0] best_sad;
  logic [3:0]  best_idx;
  logic        err;

  sad_best_match #(
    .NUM_CAND (16),
    .IDX_W    (4),
    .SAD_W    (32),
    .TIMEOUT  (16)
  ) u_dut (
    .clk       (clk),
    .Mrst      (Mrst),
    .start     (start),
    .sad_go    (sad_go),
    .cand_idx  (cand_idx),
    .sad_valid (sad_valid),
    .sad       (sad),
    .busy      (busy),
    .done      (done),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: answers 4 cycles after sad_go with sad_tab[cand], unless silent.
  logic [31:0] sad_tab [16];
  int          silent_idx   = -1;
  bit          stray_cmp_en = 1'b0;
  logic        stray_v      = 1'b0;
  int          eng_cnt      = 0;
  logic [3:0]  eng_idx      = '0;
  logic        eng_v        = 1'b0;
  logic [31:0] eng_sad      = '0;
  bit          prev_real    = 1'b0;
  int          go_cnt       = 0;
  int          done_cnt     = 0;
  int          busy_cnt     = 0;

  assign sad_valid = eng_v | stray_v;
  assign sad       = stray_v ? 32'd0 : eng_sad;

  always @(negedge clk) begin
    bit real_now;
    real_now = 1'b0;
    eng_v    = 1'b0;
    // Optional stray zero-valued result during the CMP cycle.
    if (stray_cmp_en && prev_real) begin
      eng_v   = 1'b1;
      eng_sad = 32'd0;
    end
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0 && int'(eng_idx) != silent_idx) begin
        eng_v    = 1'b1;
        eng_sad  = sad_tab[eng_idx];
        real_now = 1'b1;
      end
    end
    prev_real = real_now;
    if (sad_go) begin
      eng_cnt = 4;
      eng_idx = cand_idx;
      go_cnt++;
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  end

  int go0, done0, busy0;

  task automatic snap();
    #1;
    go0   = go_cnt;
    done0 = done_cnt;
    busy0 = busy_cnt;
  endtask

  // Pulse start, then wait (bounded) for done; leaves time at the negedge after done.
  task automatic run_search(input string tag);
    int g;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    check_eq({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    check_eq({tag, "_idle"}, {63'd0, busy}, 64'd0);
    #1;
  endtask

  task automatic fill_tab(input logic [31:0] v);
    for (int i = 0; i < 16; i++) sad_tab[i] = v;
  endtask

  initial begin
    Mrst  = 1'b0;
    start = 1'b0;
    fill_tab(32'd0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy",     {63'd0, busy},     64'd0);
    check_eq("rst_go",       {63'd0, sad_go},   64'd0);
    check_eq("rst_done",     {63'd0, done},     64'd0);
    check_eq("rst_err",      {63'd0, err},      64'd0);
    check_eq("rst_cand",     {60'd0, cand_idx}, 64'd0);
    check_eq("rst_best_sad", {32'd0, best_sad}, 64'hFFFF_FFFF);
    check_eq("rst_best_idx", {60'd0, best_idx}, 64'd0);
    Mrst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: decreasing SADs, last candidate wins; 16 x 6 cycles + 1 FIN busy
    for (int i = 0; i < 16; i++) sad_tab[i] = 32'(100 - i);
    snap();
    run_search("t1");
    check_eq("t1_best_sad", {32'd0, best_sad}, 64'd85);
    check_eq("t1_best_idx", {60'd0, best_idx}, 64'd15);
    check_eq("t1_err",      {63'd0, err},      64'd0);
    check_eq("t1_go_pulses",   64'(go_cnt - go0),     64'd16);
    check_eq("t1_done_pulses", 64'(done_cnt - done0), 64'd1);
    check_eq("t1_busy_cycles", 64'(busy_cnt - busy0), 64'd97);

    // 2: all equal, tie keeps index 0
    fill_tab(32'd500);
    run_search("t2");
    check_eq("t2_best_sad", {32'd0, best_sad}, 64'd500);
    check_eq("t2_best_idx", {60'd0, best_idx}, 64'd0);

    // 3: two equal minima, earlier one wins
    fill_tab(32'd1000);
    sad_tab[7]  = 32'd3;
    sad_tab[12] = 32'd3;
    run_search("t3");
    check_eq("t3_best_sad", {32'd0, best_sad}, 64'd3);
    check_eq("t3_best_idx", {60'd0, best_idx}, 64'd7);

    // all-ones results never beat the initial value
    fill_tab(32'hFFFF_FFFF);
    run_search("t3b");
    check_eq("t3b_best_sad", {32'd0, best_sad}, 64'hFFFF_FFFF);
    check_eq("t3b_best_idx", {60'd0, best_idx}, 64'd0);

    // 4: engine silent on candidate 5 -> timeout, best of 0..4 kept
    for (int i = 0; i < 16; i++) sad_tab[i] = 32'(100 - i);
    silent_idx = 5;
    snap();
    run_search("t4");
    check_eq("t4_err",      {63'd0, err},      64'd1);
    check_eq("t4_best_sad", {32'd0, best_sad}, 64'd96);
    check_eq("t4_best_idx", {60'd0, best_idx}, 64'd4);
    check_eq("t4_go_pulses",   64'(go_cnt - go0),     64'd6);
    check_eq("t4_done_pulses", 64'(done_cnt - done0), 64'd1);
    // LAUNCH x6 + WAIT 4x5 + 16 + CMP x5 + FIN
    check_eq("t4_busy_cycles", 64'(busy_cnt - busy0), 64'd48);
    repeat (3) @(negedge clk);
    check_eq("t4_err_held", {63'd0, err}, 64'd1);
    silent_idx = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("t4_err_cleared", {63'd0, err},      64'd0);
    check_eq("t4_restart_busy", {63'd0, busy},    64'd1);
    begin
      int g;
      g = 0;
      while (!done && g < 3000) begin
        @(negedge clk);
        g++;
      end
      check_eq("t4_rerun_done", {63'd0, done}, 64'd1);
    end
    @(negedge clk);
    check_eq("t4_rerun_best", {32'd0, best_sad}, 64'd85);

    // 5: start while busy, stray zero-valued results in CMP and IDLE
    fill_tab(32'd40);
    sad_tab[9] = 32'd20;
    stray_cmp_en = 1'b1;
    snap();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    begin
      int g;
      g = 0;
      while (!done && g < 3000) begin
        @(negedge clk);
        g++;
      end
      check_eq("t5_done_seen", {63'd0, done}, 64'd1);
    end
    @(negedge clk);
    stray_cmp_en = 1'b0;
    check_eq("t5_best_sad", {32'd0, best_sad}, 64'd20);
    check_eq("t5_best_idx", {60'd0, best_idx}, 64'd9);
    #1;
    check_eq("t5_go_pulses",   64'(go_cnt - go0),     64'd16);
    check_eq("t5_done_pulses", 64'(done_cnt - done0), 64'd1);
    check_eq("t5_busy_cycles", 64'(busy_cnt - busy0), 64'd97);
    snap();
    @(negedge clk);
    stray_v = 1'b1;
    @(negedge clk);
    stray_v = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_idle_busy",     {63'd0, busy},     64'd0);
    check_eq("t5_idle_best_sad", {32'd0, best_sad}, 64'd20);
    check_eq("t5_idle_best_idx", {60'd0, best_idx}, 64'd9);
    #1;
    check_eq("t5_idle_go", 64'(go_cnt - go0), 64'd0);

    // 6: async reset during WAIT of candidate 9
    for (int i = 0; i < 16; i++) sad_tab[i] = 32'(100 - i);
    snap();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int g;
      g = 0;
      while (go_cnt < go0 + 10 && g < 3000) begin
        @(posedge clk);
        g++;
      end
      check_eq("t6_reached_c9", 64'(go_cnt - go0), 64'd10);
    end
    @(negedge clk);
    #2;
    Mrst = 1'b0;
    #1;
    check_eq("t6_busy",     {63'd0, busy},     64'd0);
    check_eq("t6_go",       {63'd0, sad_go},   64'd0);
    check_eq("t6_cand",     {60'd0, cand_idx}, 64'd0);
    check_eq("t6_best_sad", {32'd0, best_sad}, 64'hFFFF_FFFF);
    check_eq("t6_best_idx", {60'd0, best_idx}, 64'd0);
    check_eq("t6_done",     {63'd0, done},     64'd0);
    repeat (6) @(negedge clk);
    Mrst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("t6_no_done", 64'(done_cnt - done0), 64'd0);
    snap();
    run_search("t6r");
    check_eq("t6r_best_sad", {32'd0, best_sad}, 64'd85);
    check_eq("t6r_best_idx", {60'd0, best_idx}, 64'd15);
    check_eq("t6r_go_pulses", 64'(go_cnt - go0), 64'd16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
